// File: rtl/image_tx_pkg.sv
// Shared types and constants for the image stream source and the accelerator top.
package image_tx_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} tx_state_t;

    localparam int PIX_W       = 32;
    localparam int IMG_W_DEF   = 28;
    localparam int IMG_H_DEF   = 28;
    localparam int PIX_PER_IMG = IMG_W_DEF * IMG_H_DEF;

endpackage

// File: rtl/image_tx_fifo.sv
// Small synchronous FIFO; entry 0 is a register that always holds the oldest beat,
// so the head output is glitch-free and stable while it waits for a pop.
module image_tx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic             pop_ok;
    logic [CNT_W-1:0] wr_idx;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign wr_idx = pop_ok ? count - CNT_W'(1) : count;
    assign head   = entries[0];

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) shifted[i] = entries[i + 1];
        shifted[DEPTH - 1] = entries[DEPTH - 1];
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end

    // A push lands just behind the surviving entries, after any shift caused by a pop.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == CNT_W'(i)) entries[i] <= push_data;
            else if (pop_ok)                 entries[i] <= shifted[i];
        end
    end

endmodule

// File: rtl/image_stream_tx.sv
// Image stream source: fetches one IMG_W x IMG_H image from a synchronous memory and
// streams it in raster order. Define IMAGE_TX_BINARIZE_EN to map pixels to +1/-1 around THRESH.
module image_stream_tx
    import image_tx_pkg::*;
#(
    parameter int DATA_W     = PIX_W,
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int NUM_IMG    = 16,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(NUM_IMG)-1:0] img_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       image_tvalid,
    output logic [DATA_W-1:0]          image_tdata,
    output logic                       image_tlast,
    input  logic                       image_tready
);

    localparam int                PIX_CNT  = IMG_W * IMG_H;
    localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int                PIX_IW   = $clog2(PIX_CNT);
    localparam logic [PIX_IW-1:0] LAST_PIX = PIX_IW'(PIX_CNT - 1);

    tx_state_t                state, state_next;
    logic [PIX_IW-1:0]        rd_cnt, tx_cnt;
    logic                     vld_p1, last_p1;
    logic signed [DATA_W-1:0] pix_p1;
    logic [DATA_W:0]          head;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty, pop, can_read;
    logic [CNT_W:0]           credit;

    function automatic logic signed [DATA_W-1:0] binarize(input logic signed [DATA_W-1:0] pix);
        logic signed [DATA_W-1:0] thr;
        thr = DATA_W'(THRESH);
        return (pix >= thr) ? DATA_W'(1) : '1;
    endfunction

    assign pop      = image_tvalid && image_tready;
    // Reads in flight plus buffered beats may never exceed the FIFO capacity.
    assign credit   = {1'b0, fifo_count} + (CNT_W + 1)'(vld_p1) - (CNT_W + 1)'(pop);
    assign can_read = credit < (CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: begin
                busy = 1'b1;
                if (can_read) begin
                    mem_rd_en = 1'b1;
                    if (rd_cnt == LAST_PIX) state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && tx_cnt == LAST_PIX) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: read issue and address/count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            mem_addr <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1  <= mem_rd_en;
            last_p1 <= mem_rd_en && (rd_cnt == LAST_PIX);
            if (state == IDLE && start) begin
                mem_addr <= ADDR_W'(img_idx) * ADDR_W'(PIX_CNT);
                rd_cnt   <= '0;
                tx_cnt   <= '0;
            end else begin
                if (mem_rd_en) begin
                    rd_cnt   <= rd_cnt + PIX_IW'(1);
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                if (pop) tx_cnt <= tx_cnt + PIX_IW'(1);
            end
        end
    end

    // Stage p1: returned data enters the FIFO the cycle after its read.
`ifdef IMAGE_TX_BINARIZE_EN
    assign pix_p1 = binarize(mem_rdata);
`else
    assign pix_p1 = mem_rdata;
`endif

    image_tx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data ({last_p1, pix_p1}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign image_tvalid = !fifo_empty;
    assign image_tdata  = fifo_empty ? '0 : head[DATA_W-1:0];
    assign image_tlast  = !fifo_empty && head[DATA_W];

endmodule

// File: tb/tb_image_stream_tx.sv
// Scoreboard bench for image_stream_tx: expected beats are queued at start and popped on handshakes.
`timescale 1ns/1ps
module tb_image_stream_tx;

    localparam int DATA_W     = 32;
    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int NUM_IMG    = 16;
    localparam int ADDR_W     = 14;
    localparam int FIFO_DEPTH = 4;
    localparam int THRESH     = 128;
    localparam int PIX        = IMG_W * IMG_H;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, start, tready;
    logic [3:0]        img_idx;
    logic              busy, done, mem_rd_en, tvalid, tlast;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata, tdata;
    bit                bin_mode = 1'b0;
    int                errors = 0;
    int                checks = 0;
    beat_t             exp_q[$];

    always #5 clk = ~clk;

    image_stream_tx #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMG(NUM_IMG),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .img_idx(img_idx), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .image_tvalid(tvalid), .image_tdata(tdata), .image_tlast(tlast), .image_tready(tready)
    );

    function automatic logic [DATA_W-1:0] mem_val(input int addr);
        if (!bin_mode) return DATA_W'(addr);
        case (addr % 4)
            0:       return DATA_W'(-5);
            1:       return DATA_W'(127);
            2:       return DATA_W'(128);
            default: return DATA_W'(255);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] exp_pix(input int addr);
        logic signed [DATA_W-1:0] v;
        v = mem_val(addr);
`ifdef IMAGE_TX_BINARIZE_EN
        return (v >= THRESH) ? DATA_W'(1) : '1;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_val(int'(mem_addr));

    task automatic load_expected(input int base);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < PIX; i++) begin
            b.data = exp_pix(base + i);
            b.last = (i == PIX - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tready = 1'b0; img_idx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, tvalid, tlast} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rd_en, tvalid, tlast});
        end
        checks++;
        if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        checks++;
        if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0d want 0", tdata); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int    beats = 0, dones = 0, done_cyc = -1, last_cyc = -1;
        beat_t b;
        img_idx = 4'd0;
        load_expected(0);
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            tready = 1'b1;
            #1;
            if (cyc == 1) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_addr !== '0) begin
                    errors++; $display("FAIL first_read: rd_en=%b addr=%0d want 1/0", mem_rd_en, mem_addr);
                end
            end
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (tvalid !== (cyc == 3)) begin
                    errors++; $display("FAIL first_valid: cycle %0d tvalid=%b want %b", cyc, tvalid, cyc == 3);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_extra_beat: got data %0d want none", tdata);
                end else begin
                    b = exp_q.pop_front();
                    if (tdata !== b.data || tlast !== b.last) begin
                        errors++; $display("FAIL basic_beat: got %0d/%b want %0d/%b", tdata, tlast, b.data, b.last);
                    end
                end
                if (tlast) last_cyc = cyc;
                beats++;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 786 || cyc == 787) begin
                checks++;
                if (busy !== (cyc == 786)) begin
                    errors++; $display("FAIL busy_edge: cycle %0d busy=%b want %b", cyc, busy, cyc == 786);
                end
            end
            start = (cyc == 0);
        end
        checks++;
        if (beats != PIX || exp_q.size() != 0) begin
            errors++; $display("FAIL basic_count: got %0d beats want %0d", beats, PIX);
        end
        checks++;
        if (last_cyc != 786) begin errors++; $display("FAIL last_cycle: got %0d want 786", last_cyc); end
        checks++;
        if (dones != 1 || done_cyc != 787) begin
            errors++; $display("FAIL done_pulse: got %0d pulses at %0d want 1 at 787", dones, done_cyc);
        end
    endtask

    task automatic test_backpressure();
        int                beats = 0, dones = 0, reads = 0, post = 0;
        bit                stalled = 1'b0;
        logic [DATA_W-1:0] held_data;
        logic              held_last;
        beat_t             b;
        img_idx = 4'd3;
        load_expected(3 * PIX);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            tready = ($urandom_range(0, 1) == 1);
            #1;
            if (stalled) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== held_data || tlast !== held_last) begin
                    errors++; $display("FAIL stall_stable: got %b/%0d/%b want 1/%0d/%b", tvalid, tdata, tlast, held_data, held_last);
                end
            end
            stalled   = tvalid && !tready;
            held_data = tdata;
            held_last = tlast;
            checks++;
            if (reads - beats > FIFO_DEPTH) begin
                errors++; $display("FAIL outstanding: got %0d want <= %0d", reads - beats, FIFO_DEPTH);
            end
            if (mem_rd_en) begin
                reads++;
                checks++;
                if (mem_addr < 14'(3 * PIX) || mem_addr > 14'(4 * PIX - 1)) begin
                    errors++; $display("FAIL read_range: got %0d want %0d..%0d", mem_addr, 3 * PIX, 4 * PIX - 1);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat: got data %0d want none", tdata);
                end else begin
                    b = exp_q.pop_front();
                    if (tdata !== b.data || tlast !== b.last) begin
                        errors++; $display("FAIL bp_beat: got %0d/%b want %0d/%b", tdata, tlast, b.data, b.last);
                    end
                end
                beats++;
            end
            if (done) dones++;
            if (dones > 0) post++;
            start = (cyc == 0) || (beats == 100) || done;
            if (post > 20) break;
        end
        start = 1'b0;
        checks++;
        if (beats != PIX || exp_q.size() != 0 || reads != PIX) begin
            errors++; $display("FAIL bp_count: got %0d beats %0d reads want %0d", beats, reads, PIX);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_rst_mid();
        int    beats = 0;
        bit    got_first = 1'b0;
        beat_t b;
        img_idx = 4'd0;
        load_expected(0);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            tready = (beats < 400);
            #1;
            if (rst) begin
                checks++;
                if (tvalid !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL rst_drop: tvalid=%b busy=%b want 0/0", tvalid, busy);
                end
                rst = 1'b0;
                break;
            end
            if (tvalid && tready) begin
                b = exp_q.pop_front();
                checks++;
                if (tdata !== b.data) begin errors++; $display("FAIL rst_beat: got %0d want %0d", tdata, b.data); end
                beats++;
            end
            if (beats == 400 && !tready) begin
                checks++;
                if (tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", tvalid); end
                rst = 1'b1;
            end
            start = (cyc == 0);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            tready = 1'b1;
            #1;
            if (tvalid) begin
                got_first = 1'b1;
                checks++;
                if (tdata !== exp_pix(0) || tlast !== 1'b0) begin
                    errors++; $display("FAIL restart_first: got %0d/%b want %0d/0", tdata, tlast, exp_pix(0));
                end
                break;
            end
            start = (cyc == 0);
        end
        start = 1'b0;
        checks++;
        if (!got_first) begin errors++; $display("FAIL restart_timeout: got no beat want one within 50 cycles"); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef IMAGE_TX_BINARIZE_EN
    task automatic test_binarize();
        logic signed [DATA_W-1:0] want [4];
        int n = 0;
        want[0] = -1; want[1] = -1; want[2] = 1; want[3] = 1;
        bin_mode = 1'b1;
        img_idx  = 4'd0;
        for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
            @(negedge clk);
            tready = 1'b1;
            #1;
            if (tvalid && tready) begin
                checks++;
                if ($signed(tdata) !== want[n]) begin
                    errors++; $display("FAIL binarize_%0d: got %0d want %0d", n, $signed(tdata), want[n]);
                end
                n++;
            end
            start = (cyc == 0);
        end
        start = 1'b0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL binarize_count: got %0d beats want 4", n); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bin_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_rst_mid();
`ifdef IMAGE_TX_BINARIZE_EN
        test_binarize();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
